// File: rtl/if_stage_fetch_ctrl.sv
// Fetch stage of the RV32I pipeline: owns the PC and the IF/ID register,
// issues one instruction-memory request at a time, buffers one response
// while decode is stalled, and drops responses that were killed by a flush.
module if_stage_fetch_ctrl #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            stall_id,
    input  logic            flush_if,
    input  logic            flush_id,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,   // nothing outstanding
        ST_WAIT,   // request outstanding at imem
        ST_FULL    // response held in the skid buffer
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic            kill_q;
    logic [XLEN-1:0] buf_pc_q;
    logic [31:0]     buf_instr_q;

    // Decoded per-cycle actions shared by the FSM and the datapath
    logic            resp_accept;   // response consumed, PC advances
    logic            resp_load;     // response goes straight into IF/ID
    logic            resp_buffer;   // response parked in the skid buffer
    logic            buf_load;      // skid buffer moves into IF/ID

    // Redirect target is always word aligned; the low two bits are discarded
    logic [XLEN-1:0] redirect_pc;
    assign redirect_pc = branch_target & ~XLEN'(3);

    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // state_d unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (imem_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = resp_buffer ? ST_FULL : ST_IDLE;
                end
            end
            ST_FULL: begin
                if (flush_if || buf_load) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and action decode
    always_comb begin
        imem_req    = 1'b0;
        resp_accept = 1'b0;
        resp_load   = 1'b0;
        resp_buffer = 1'b0;
        buf_load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                imem_req = rst_n && !stall_if && !branch_taken && !flush_if;
            end
            ST_WAIT: begin
                // A killed or same-cycle-flushed response is simply dropped
                if (imem_rvalid && !kill_q && !flush_if) begin
                    resp_accept = 1'b1;
                    if (!stall_id && !flush_id) begin
                        resp_load = 1'b1;
                    end else begin
                        resp_buffer = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                // flush_if wins over moving the buffered instruction
                buf_load = !flush_if && !stall_id && !flush_id;
            end
            default: ;
        endcase
    end

    // Program counter: redirect beats sequential advance; +4 wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= redirect_pc;
        end else if (resp_accept) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // Kill flag: remembers a flush that hit while a request was outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kill_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (imem_rvalid) begin
                kill_q <= 1'b0;
            end else if (flush_if) begin
                kill_q <= 1'b1;
            end
        end
    end

    // Skid buffer holding one response while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
        end else if (resp_buffer) begin
            buf_pc_q    <= pc_q;
            buf_instr_q <= imem_rdata;
        end
    end

    // IF/ID register: flush > stall > new data > bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (flush_id) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (stall_id) begin
            if_id_valid <= if_id_valid;
        end else if (resp_load) begin
            if_id_pc    <= pc_q;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end else if (buf_load) begin
            if_id_pc    <= buf_pc_q;
            if_id_instr <= buf_instr_q;
            if_id_valid <= 1'b1;
        end else begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end
    end

    // imem may only answer while exactly one request is outstanding
    a_rvalid_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (state_q == ST_WAIT)
    );

endmodule
